// File: rtl/spi_temp_pkg.sv
// Shared types and constants for the SPI temperature responder.
// The state encoding, command codes and response decoding live here.
package spi_temp_pkg;

   localparam int CMD_BITS  = 8;
   localparam int DATA_BITS = 16;

   localparam logic [CMD_BITS-1:0]  CMD_RD_TEMP = 8'h01;
   localparam logic [CMD_BITS-1:0]  CMD_RD_ID   = 8'h02;
   localparam logic [CMD_BITS-1:0]  CMD_RD_STAT = 8'h03;
   localparam logic [DATA_BITS-1:0] ERR_DATA    = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef struct packed {
      logic                 err;
      logic [DATA_BITS-1:0] data;
   } resp_t;

   // Unknown commands answer all-ones and flag an error.
   function automatic resp_t decode_cmd(input logic [CMD_BITS-1:0]  cmd,
                                        input logic [DATA_BITS-1:0] temp,
                                        input logic                 fresh,
                                        input logic [DATA_BITS-1:0] dev_id);
      resp_t r;
      r.err  = 1'b0;
      r.data = ERR_DATA;
      case (cmd)
         CMD_RD_TEMP: r.data = temp;
         CMD_RD_ID:   r.data = dev_id;
         CMD_RD_STAT: r.data = {{(DATA_BITS-1){1'b0}}, fresh};
         default:     r.err  = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// RST_VAL sets the value the chain holds during reset.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_in_p,
   input  logic rst_n_p,
   input  logic d_p,
   output logic q_p
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_p};
   end

   always_ff @(posedge clk_in_p or negedge rst_n_p) begin
      if (!rst_n_p) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_p = sync_q[STAGES-1];

endmodule

// File: rtl/spi_temp_slave.sv
// SPI mode-0 responder returning a temperature sample, device ID or status.
// Optional macro SPI_TEMP_SLAVE_TRISTATE_EN floats miso_p while deselected.
module spi_temp_slave
   import spi_temp_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] DEVICE_ID   = 16'h0A5C
) (
   input  logic        clk_in_p,
   input  logic        rst_n_p,
   input  logic        sclk_p,
   input  logic        cs_n_p,
   input  logic        mosi_p,
   output logic        miso_p,
   input  logic [15:0] temp_p,
   input  logic        temp_vld_p,
   output logic        frame_done_p,
   output logic        cmd_err_p
);

   localparam logic [1:0] FLUSH_MAX = 2'(SYNC_STAGES);

   logic sclk_s, cs_s, mosi_s;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk_in_p(clk_in_p), .rst_n_p(rst_n_p), .d_p(sclk_p), .q_p(sclk_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk_in_p(clk_in_p), .rst_n_p(rst_n_p), .d_p(cs_n_p), .q_p(cs_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk_in_p(clk_in_p), .rst_n_p(rst_n_p), .d_p(mosi_p), .q_p(mosi_s));

   state_e state_q, state_d;

   logic                 sclk_prev_q, sclk_prev_d;
   logic                 cs_prev_q, cs_prev_d;
   logic [1:0]           flush_cnt_q, flush_cnt_d;
   logic                 armed_q, armed_d;
   logic [DATA_BITS-1:0] shadow_q, shadow_d;
   logic                 fresh_q, fresh_d;
   logic [DATA_BITS-1:0] snap_temp_q, snap_temp_d;
   logic                 snap_fresh_q, snap_fresh_d;
   logic [CMD_BITS-1:0]  cmd_sr_q, cmd_sr_d;
   logic [DATA_BITS-1:0] resp_sr_q, resp_sr_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic                 miso_q, miso_d;
   logic                 frame_done_q, frame_done_d;
   logic                 cmd_err_q, cmd_err_d;

   logic                cs_fall, cs_rise, sclk_rise, sclk_fall;
   logic                cmd_last, data_last;
   logic [CMD_BITS-1:0] cmd_next;
   resp_t               dec;

   // A low cs_n seen straight out of reset must not start a frame, so falling
   // edges count only once a genuine high has passed through the synchronizer.
   assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
   assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
   assign cmd_last  = (bit_cnt_q == 4'(CMD_BITS - 1));
   assign data_last = (bit_cnt_q == 4'(DATA_BITS - 1));
   assign cmd_next  = {cmd_sr_q[CMD_BITS-2:0], mosi_s};
   assign dec       = decode_cmd(cmd_next, snap_temp_q, snap_fresh_q, DEVICE_ID);

   always_ff @(posedge clk_in_p or negedge rst_n_p) begin
      if (!rst_n_p) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (cs_rise) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (cs_fall)               state_d = ST_CMD;
            ST_CMD:  if (sclk_rise && cmd_last)  state_d = ST_DATA;
            ST_DATA: if (sclk_rise && data_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      sclk_prev_d  = sclk_s;
      cs_prev_d    = cs_s;
      flush_cnt_d  = (flush_cnt_q == FLUSH_MAX) ? flush_cnt_q : flush_cnt_q + 2'd1;
      armed_d      = armed_q | ((flush_cnt_q == FLUSH_MAX) & cs_s);
      shadow_d     = shadow_q;
      fresh_d      = fresh_q;
      snap_temp_d  = snap_temp_q;
      snap_fresh_d = snap_fresh_q;
      cmd_sr_d     = cmd_sr_q;
      resp_sr_d    = resp_sr_q;
      bit_cnt_d    = bit_cnt_q;
      miso_d       = miso_q;
      frame_done_d = 1'b0;
      cmd_err_d    = 1'b0;

      if (temp_vld_p) begin
         shadow_d = temp_p;
         fresh_d  = 1'b1;
      end

      if (cs_rise) begin
         miso_d    = 1'b0;
         bit_cnt_d = 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               miso_d = 1'b0;
               if (cs_fall) begin
                  snap_temp_d  = shadow_q;
                  snap_fresh_d = fresh_q;
                  cmd_sr_d     = '0;
                  bit_cnt_d    = 4'd0;
               end
            end
            ST_CMD: begin
               miso_d = 1'b0;
               if (sclk_rise) begin
                  cmd_sr_d = cmd_next;
                  if (cmd_last) begin
                     bit_cnt_d = 4'd0;
                     resp_sr_d = dec.data;
                     cmd_err_d = dec.err;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_DATA: begin
               if (sclk_fall) begin
                  miso_d    = resp_sr_q[DATA_BITS-1];
                  resp_sr_d = {resp_sr_q[DATA_BITS-2:0], 1'b0};
               end
               if (sclk_rise) begin
                  if (data_last) begin
                     bit_cnt_d    = 4'd0;
                     frame_done_d = 1'b1;
                     // A sample arriving in this very cycle keeps the flag set.
                     if (cmd_sr_q == CMD_RD_TEMP && !temp_vld_p) begin
                        fresh_d = 1'b0;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            default: miso_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_in_p or negedge rst_n_p) begin
      if (!rst_n_p) begin
         sclk_prev_q  <= 1'b0;
         cs_prev_q    <= 1'b1;
         flush_cnt_q  <= 2'd0;
         armed_q      <= 1'b0;
         shadow_q     <= '0;
         fresh_q      <= 1'b0;
         snap_temp_q  <= '0;
         snap_fresh_q <= 1'b0;
         cmd_sr_q     <= '0;
         resp_sr_q    <= '0;
         bit_cnt_q    <= 4'd0;
         miso_q       <= 1'b0;
         frame_done_q <= 1'b0;
         cmd_err_q    <= 1'b0;
      end else begin
         sclk_prev_q  <= sclk_prev_d;
         cs_prev_q    <= cs_prev_d;
         flush_cnt_q  <= flush_cnt_d;
         armed_q      <= armed_d;
         shadow_q     <= shadow_d;
         fresh_q      <= fresh_d;
         snap_temp_q  <= snap_temp_d;
         snap_fresh_q <= snap_fresh_d;
         cmd_sr_q     <= cmd_sr_d;
         resp_sr_q    <= resp_sr_d;
         bit_cnt_q    <= bit_cnt_d;
         miso_q       <= miso_d;
         frame_done_q <= frame_done_d;
         cmd_err_q    <= cmd_err_d;
      end
   end

   assign frame_done_p = frame_done_q;
   assign cmd_err_p    = cmd_err_q;

`ifdef SPI_TEMP_SLAVE_TRISTATE_EN
   assign miso_p = (!rst_n_p || cs_s) ? 1'bz : miso_q;
`else
   assign miso_p = cs_s ? 1'b0 : miso_q;
`endif

endmodule

// File: doc/spi_temp_slave.md
SPI_TEMP_SLAVE -- requirements
Module: spi_temp_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for sclk_p, cs_n_p and mosi_p; legal values are 2 to 3.
REQ-002 Parameter DEVICE_ID, default 16'h0A5C: value returned by the read-ID command.
REQ-003 Port clk_in_p, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port rst_n_p, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port sclk_p, input, 1 bit: SPI clock from the master; asynchronous to clk_in_p.
REQ-006 Port cs_n_p, input, 1 bit: SPI chip select, active-low.
REQ-007 Port mosi_p, input, 1 bit: master-to-slave data.
REQ-008 Port miso_p, output, 1 bit: slave-to-master data.
REQ-009 Port temp_p, input, 16 bits: parallel temperature sample.
REQ-010 Port temp_vld_p, input, 1 bit: one-cycle strobe; when high, temp_p is valid.
REQ-011 Port frame_done_p, output, 1 bit: one-cycle pulse when a frame completes.
REQ-012 Port cmd_err_p, output, 1 bit: one-cycle pulse when an unknown command is received.

Function
REQ-013 The block SHALL act as an SPI mode-0 responder, oversampled by clk_in_p:
- inputs pass through SYNC_STAGES flops, then edge detection;
- legal operation requires an sclk_p period of at least 8 clk_in_p periods.
REQ-014 The block SHALL latch temp_p into a shadow register in the cycle temp_vld_p is high, and set the fresh flag.
REQ-015 On a synchronized cs_n_p falling edge, the block SHALL snapshot the shadow register and the fresh flag, then enter state CMD.
REQ-016 The state machine SHALL have these states and transitions:
- IDLE -> CMD on cs_n_p falling;
- CMD -> DATA after the 8th sclk rising edge;
- DATA -> DONE after the 16th data rising edge;
- DONE -> IDLE on cs_n_p rising;
- any state -> IDLE on cs_n_p rising.
REQ-017 In CMD, the block SHALL shift mosi_p in MSB first on each synchronized sclk rising edge.
REQ-018 The block SHALL decode the command byte as follows:
- 8'h01 returns the temperature snapshot;
- 8'h02 returns DEVICE_ID;
- 8'h03 returns {15'b0, fresh snapshot};
- any other value returns 16'hFFFF and pulses cmd_err_p once, in the cycle after the 8th rising edge.
REQ-019 The block SHALL present response bit 15 on miso_p in the cycle after the 8th sclk falling edge, i.e. before the 9th rising edge.
REQ-020 Each later falling edge SHALL shift the next bit out, MSB first.
REQ-021 miso_p SHALL be 0 in the following cases:
- during CMD;
- in DONE, including any extra sclk edges;
- in IDLE (see REQ-033 for the alternative).
REQ-022 frame_done_p SHALL pulse once, in the cycle after the 16th data rising edge.
REQ-023 A completed 8'h01 frame SHALL clear the fresh flag, unless temp_vld_p is high in that same cycle; in that case the flag stays set and the shadow register takes the new value.
REQ-024 temp_vld_p during a frame SHALL update the shadow register only; the in-flight response is unchanged.
REQ-025 If cs_n_p rises mid-frame, the block SHALL abort with:
- no frame_done_p and no cmd_err_p pulse;
- the fresh flag unchanged;
- a return to IDLE in the cycle after the synchronized rising edge.
REQ-026 sclk_p edges while cs_n_p is high SHALL be ignored.

Reset
REQ-027 While rst_n_p is low, the block SHALL hold:
- state IDLE;
- shadow register 16'h0000 and fresh flag 0;
- all shift registers and counters at 0;
- miso_p, frame_done_p and cmd_err_p at 0;
- synchronizer flops at cs_n=1, sclk=0 and mosi=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately and produce no pulses.
REQ-029 After rst_n_p deassertion, a frame SHALL only start on a fresh cs_n_p falling edge; a cs_n_p that is already low is ignored until it goes high and falls again.

Configuration
REQ-030 The macro SPI_TEMP_SLAVE_TRISTATE_EN SHALL be the only compile-time option.
REQ-031 With SPI_TEMP_SLAVE_TRISTATE_EN defined, miso_p SHALL be 1'bz whenever the synchronized cs_n_p is high, and during reset.
REQ-032 With SPI_TEMP_SLAVE_TRISTATE_EN defined, miso_p SHALL be driven per REQ-019 to REQ-021 while the synchronized cs_n_p is low.
REQ-033 Without SPI_TEMP_SLAVE_TRISTATE_EN, miso_p SHALL be driven 0 whenever the synchronized cs_n_p is high.

Structure
REQ-034 Package spi_temp_pkg SHALL hold:
- the state enum type;
- command localparams CMD_RD_TEMP, CMD_RD_ID and CMD_RD_STAT;
- the constants CMD_BITS=8, DATA_BITS=16 and ERR_DATA=16'hFFFF.
REQ-035 Sub-module spi_sync SHALL implement the parameterized multi-flop synchronizer; it is instantiated three times.

Verification
REQ-036 Read temperature: pulse temp_vld_p with temp_p=16'h1A3C, then send cmd 8'h01 with sclk at 10 clk_in_p periods -> miso_p returns 16'h1A3C, and frame_done_p pulses once.
REQ-037 Read ID: cmd 8'h02 -> 16'h0A5C; then cmd 8'h03 after a prior 8'h01 read with no new temp_vld_p -> 16'h0000.
REQ-038 Bad command: cmd 8'h7E -> cmd_err_p pulses once after bit 8, and miso_p returns 16'hFFFF.
REQ-039 Abort: raise cs_n_p after 12 sclk edges of an 8'h01 frame -> IDLE, no pulses, and a following 8'h03 frame returns 16'h0001.
REQ-040 Update during frame: temp_vld_p with 16'h5555 mid-frame of an 8'h01 read of 16'h1111 -> the frame returns 16'h1111, and the next 8'h01 read returns 16'h5555.
REQ-041 Reset mid-frame, plus both macro builds:
- assert rst_n_p during DATA -> all outputs are 0 and there is no frame_done_p;
- with SPI_TEMP_SLAVE_TRISTATE_EN defined, check that miso_p is z while cs_n_p is high.
